// File: rtl/vga_pkg.sv
//------------------------------------------------------------------------------
// Module      : vga_pkg
// Description : Shared 640x480@60 timing defaults, total-count helpers and the
//               control tuple carried alongside each pixel request.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

package vga_pkg;

  localparam int c_h_active = 640;
  localparam int c_h_fp     = 16;
  localparam int c_h_sync   = 96;
  localparam int c_h_bp     = 48;
  localparam int c_v_active = 480;
  localparam int c_v_fp     = 10;
  localparam int c_v_sync   = 2;
  localparam int c_v_bp     = 33;
  localparam int c_cw       = 10;

  function automatic int h_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  function automatic int v_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  typedef struct packed {
    logic valid;
    logic hs;
    logic vs;
  } vga_ctrl_t;

endpackage

`default_nettype wire

// File: rtl/vga_delay_line.sv
//------------------------------------------------------------------------------
// Module      : vga_delay_line
// Description : DEPTH-stage shift register with synchronous clear.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module vga_delay_line #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [(DEPTH+1)*WIDTH-1:0] w_chain;

  assign w_chain[WIDTH-1:0] = i_d;

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic [WIDTH-1:0] r_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        r_q <= '0;
      end else begin
        r_q <= w_chain[i*WIDTH +: WIDTH];
      end
    end

    assign w_chain[(i+1)*WIDTH +: WIDTH] = r_q;
  end

  assign o_q = w_chain[DEPTH*WIDTH +: WIDTH];

endmodule

`default_nettype wire

// File: rtl/vga_timing_ctrl.sv
//------------------------------------------------------------------------------
// Module      : vga_timing_ctrl
// Description : Raster counters, early pixel requests and registered VGA outputs
//               aligned LATENCY+1 cycles after each request.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module vga_timing_ctrl
  import vga_pkg::*;
#(
  parameter int   H_ACTIVE = c_h_active,
  parameter int   H_FP     = c_h_fp,
  parameter int   H_SYNC   = c_h_sync,
  parameter int   H_BP     = c_h_bp,
  parameter int   V_ACTIVE = c_v_active,
  parameter int   V_FP     = c_v_fp,
  parameter int   V_SYNC   = c_v_sync,
  parameter int   V_BP     = c_v_bp,
  parameter logic HS_POL   = 1'b0,
  parameter logic VS_POL   = 1'b0,
  parameter int   LATENCY  = 2,
  parameter int   CW       = c_cw
) (
  input  logic          vga_clk,
  input  logic          reset,
  output logic          req_valid,
  output logic [CW-1:0] req_x,
  output logic [CW-1:0] req_y,
  output logic          frame_start,
  output logic          line_start,
  input  logic [7:0]    pix_r,
  input  logic [7:0]    pix_g,
  input  logic [7:0]    pix_b,
  output logic          vga_hs,
  output logic          vga_vs,
  output logic [7:0]    vga_r,
  output logic [7:0]    vga_g,
  output logic [7:0]    vga_b,
  output logic          vga_blank_n,
  output logic          vga_sync_n
);

  localparam int c_h_total = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int c_v_total = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  localparam logic [CW-1:0] c_h_last     = CW'(c_h_total - 1);
  localparam logic [CW-1:0] c_v_last     = CW'(c_v_total - 1);
  localparam logic [CW-1:0] c_h_act      = CW'(H_ACTIVE);
  localparam logic [CW-1:0] c_v_act      = CW'(V_ACTIVE);
  localparam logic [CW-1:0] c_hs_start   = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] c_hs_end     = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] c_vs_start   = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] c_vs_end     = CW'(V_ACTIVE + V_FP + V_SYNC);

  logic [CW-1:0] r_hcnt;
  logic [CW-1:0] r_vcnt;
  logic          w_h_wrap;
  logic          w_v_wrap;
  logic          w_hsync_raw;
  logic          w_vsync_raw;
  vga_ctrl_t     w_ctrl_req;
  vga_ctrl_t     w_ctrl_dly;

  logic          r_hs;
  logic          r_vs;
  logic          r_blank_n;
  logic [7:0]    r_r;
  logic [7:0]    r_g;
  logic [7:0]    r_b;

  assign w_h_wrap = (r_hcnt == c_h_last);
  assign w_v_wrap = (r_vcnt == c_v_last);

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      r_hcnt <= '0;
      r_vcnt <= '0;
    end else if (w_h_wrap) begin
      r_hcnt <= '0;
      r_vcnt <= w_v_wrap ? '0 : r_vcnt + CW'(1);
    end else begin
      r_hcnt <= r_hcnt + CW'(1);
    end
  end

  assign req_x       = r_hcnt;
  assign req_y       = r_vcnt;
  assign req_valid   = (r_hcnt < c_h_act) && (r_vcnt < c_v_act);
  assign line_start  = (r_hcnt == '0);
  assign frame_start = (r_hcnt == '0) && (r_vcnt == '0);

  // vsync covers whole lines, so it only moves when vcnt does (on the hcnt wrap)
  assign w_hsync_raw = (r_hcnt >= c_hs_start) && (r_hcnt < c_hs_end);
  assign w_vsync_raw = (r_vcnt >= c_vs_start) && (r_vcnt < c_vs_end);

  assign w_ctrl_req.valid = req_valid;
  assign w_ctrl_req.hs    = w_hsync_raw;
  assign w_ctrl_req.vs    = w_vsync_raw;

  vga_delay_line #(
    .DEPTH (LATENCY),
    .WIDTH ($bits(vga_ctrl_t))
  ) u_delay_line (
    .clk (vga_clk),
    .rst (reset),
    .i_d (w_ctrl_req),
    .o_q (w_ctrl_dly)
  );

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      r_hs      <= ~HS_POL;
      r_vs      <= ~VS_POL;
      r_blank_n <= 1'b0;
      r_r       <= 8'd0;
      r_g       <= 8'd0;
      r_b       <= 8'd0;
    end else begin
      r_hs      <= w_ctrl_dly.hs ? HS_POL : ~HS_POL;
      r_vs      <= w_ctrl_dly.vs ? VS_POL : ~VS_POL;
      r_blank_n <= w_ctrl_dly.valid;
      r_r       <= w_ctrl_dly.valid ? pix_r : 8'd0;
      r_g       <= w_ctrl_dly.valid ? pix_g : 8'd0;
      r_b       <= w_ctrl_dly.valid ? pix_b : 8'd0;
    end
  end

  assign vga_hs      = r_hs;
  assign vga_vs      = r_vs;
  assign vga_blank_n = r_blank_n;
  assign vga_r       = r_r;
  assign vga_g       = r_g;
  assign vga_b       = r_b;
  assign vga_sync_n  = 1'b0;

endmodule

`default_nettype wire

// File: tb/tb_vga_timing_ctrl.sv
//------------------------------------------------------------------------------
// Module      : tb_vga_timing_ctrl
// Description : Scoreboard bench over four timing/latency/polarity variants.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_vga_timing_ctrl;

  localparam int c_n = 4;
  localparam int c_ha  [c_n] = '{640, 20, 20, 20};
  localparam int c_hfp [c_n] = '{16, 3, 3, 3};
  localparam int c_hsy [c_n] = '{96, 4, 4, 4};
  localparam int c_hbp [c_n] = '{48, 5, 5, 5};
  localparam int c_va  [c_n] = '{480, 10, 10, 10};
  localparam int c_vfp [c_n] = '{10, 2, 2, 2};
  localparam int c_vsy [c_n] = '{2, 2, 2, 2};
  localparam int c_vbp [c_n] = '{33, 3, 3, 3};
  localparam bit c_hsp [c_n] = '{1'b0, 1'b0, 1'b1, 1'b0};
  localparam bit c_vsp [c_n] = '{1'b0, 1'b0, 1'b0, 1'b1};
  localparam int c_lat [c_n] = '{2, 2, 1, 8};

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic       blank_n;
    logic [23:0] rgb;
  } exp_t;

  logic       vga_clk = 1'b0;
  logic       reset   = 1'b1;
  logic       req_valid   [c_n];
  logic [9:0] req_x       [c_n];
  logic [9:0] req_y       [c_n];
  logic       frame_start [c_n];
  logic       line_start  [c_n];
  logic [7:0] pix_r       [c_n];
  logic [7:0] pix_g       [c_n];
  logic [7:0] pix_b       [c_n];
  logic       vga_hs      [c_n];
  logic       vga_vs      [c_n];
  logic [7:0] vga_r       [c_n];
  logic [7:0] vga_g       [c_n];
  logic [7:0] vga_b       [c_n];
  logic       vga_blank_n [c_n];
  logic       vga_sync_n  [c_n];

  for (genvar gi = 0; gi < c_n; gi++) begin : g_dut
    vga_timing_ctrl #(
      .H_ACTIVE (c_ha[gi]),  .H_FP (c_hfp[gi]), .H_SYNC (c_hsy[gi]), .H_BP (c_hbp[gi]),
      .V_ACTIVE (c_va[gi]),  .V_FP (c_vfp[gi]), .V_SYNC (c_vsy[gi]), .V_BP (c_vbp[gi]),
      .HS_POL   (c_hsp[gi]), .VS_POL (c_vsp[gi]), .LATENCY (c_lat[gi]), .CW (10)
    ) u_dut (
      .vga_clk     (vga_clk),
      .reset       (reset),
      .req_valid   (req_valid[gi]),
      .req_x       (req_x[gi]),
      .req_y       (req_y[gi]),
      .frame_start (frame_start[gi]),
      .line_start  (line_start[gi]),
      .pix_r       (pix_r[gi]),
      .pix_g       (pix_g[gi]),
      .pix_b       (pix_b[gi]),
      .vga_hs      (vga_hs[gi]),
      .vga_vs      (vga_vs[gi]),
      .vga_r       (vga_r[gi]),
      .vga_g       (vga_g[gi]),
      .vga_b       (vga_b[gi]),
      .vga_blank_n (vga_blank_n[gi]),
      .vga_sync_n  (vga_sync_n[gi])
    );
  end

  initial forever #20 vga_clk = ~vga_clk;

  exp_t        exp_q   [c_n][$];
  int          pos     [c_n];
  logic [23:0] col_mem [c_n][64];
  bit          armed   = 1'b0;
  bit          done    = 1'b0;
  bit          to_err  = 1'b0;
  int          n_cmp   = 0;
  int          n_bad   = 0;

  function automatic int ht(input int k);
    return c_ha[k] + c_hfp[k] + c_hsy[k] + c_hbp[k];
  endfunction

  function automatic int vt(input int k);
    return c_va[k] + c_vfp[k] + c_vsy[k] + c_vbp[k];
  endfunction

  // Reference model + renderer: pos is the linear raster position since reset.
  initial begin : model
    int h, v;
    logic act, hsr, vsr;
    logic [23:0] col;
    exp_t e;
    for (int k = 0; k < c_n; k++) begin
      pos[k] = 0; pix_r[k] = 8'd0; pix_g[k] = 8'd0; pix_b[k] = 8'd0;
    end
    forever begin
      @(posedge vga_clk);
      #1;
      for (int k = 0; k < c_n; k++) begin
        if (reset) begin
          pos[k] = 0;
          exp_q[k].delete();
        end else begin
          pos[k]++;
        end
        h   = pos[k] % ht(k);
        v   = (pos[k] / ht(k)) % vt(k);
        act = (h < c_ha[k]) && (v < c_va[k]);
        hsr = (h >= c_ha[k] + c_hfp[k]) && (h < c_ha[k] + c_hfp[k] + c_hsy[k]);
        vsr = (v >= c_va[k] + c_vfp[k]) && (v < c_va[k] + c_vfp[k] + c_vsy[k]);
        col = 24'($urandom);
        if (!act && ($urandom_range(0, 1) == 1)) col = 24'hFFFFFF;
        col_mem[k][pos[k] % 64] = col;
        e.hs      = hsr ? c_hsp[k] : !c_hsp[k];
        e.vs      = vsr ? c_vsp[k] : !c_vsp[k];
        e.blank_n = act;
        e.rgb     = act ? col : 24'h0;
        exp_q[k].push_back(e);
        if (pos[k] >= c_lat[k]) begin
          {pix_r[k], pix_g[k], pix_b[k]} = col_mem[k][(pos[k] - c_lat[k]) % 64];
        end else begin
          {pix_r[k], pix_g[k], pix_b[k]} = 24'($urandom);
        end
      end
      if (reset) armed = 1'b1;
    end
  end

  initial begin : monitor
    int h, v;
    exp_t e_exp, e_got;
    logic [22:0] r_exp, r_got;
    bit seen [c_n];
    logic prev_hs [c_n];
    forever begin
      @(negedge vga_clk);
      if (done) begin
        if (to_err) begin
          n_cmp++; n_bad++;
          $display("FAIL wait_timeout: raster position never reached");
        end
        for (int k = 0; k < c_n; k++) begin
          n_cmp++;
          if (!seen[k]) begin
            n_bad++;
            $display("FAIL first_hs[%0d]: got no hsync edge, need one", k);
          end
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
      end
      if (armed) begin
        for (int k = 0; k < c_n; k++) begin
          h = pos[k] % ht(k);
          v = (pos[k] / ht(k)) % vt(k);
          r_exp = {(h < c_ha[k]) && (v < c_va[k]), h == 0, (h == 0) && (v == 0), 10'(h), 10'(v)};
          r_got = {req_valid[k], line_start[k], frame_start[k], req_x[k], req_y[k]};
          n_cmp++;
          if (r_got !== r_exp) begin
            n_bad++;
            $display("FAIL req[%0d] pos=%0d: got v/ls/fs/x/y=%b%b%b/%0d/%0d need %b%b%b/%0d/%0d",
                     k, pos[k], r_got[22], r_got[21], r_got[20], r_got[19:10], r_got[9:0],
                     r_exp[22], r_exp[21], r_exp[20], r_exp[19:10], r_exp[9:0]);
          end

          if (exp_q[k].size() > c_lat[k] + 1) begin
            e_exp = exp_q[k].pop_front();
          end else begin
            e_exp = '{hs: !c_hsp[k], vs: !c_vsp[k], blank_n: 1'b0, rgb: 24'h0};
          end
          e_got = '{hs: vga_hs[k], vs: vga_vs[k], blank_n: vga_blank_n[k],
                    rgb: {vga_r[k], vga_g[k], vga_b[k]}};
          n_cmp++;
          if (e_got !== e_exp) begin
            n_bad++;
            $display("FAIL vga[%0d] pos=%0d: got hs/vs/blank_n/rgb=%b/%b/%b/%h need %b/%b/%b/%h",
                     k, pos[k], e_got.hs, e_got.vs, e_got.blank_n, e_got.rgb,
                     e_exp.hs, e_exp.vs, e_exp.blank_n, e_exp.rgb);
          end

          n_cmp++;
          if (vga_sync_n[k] !== 1'b0) begin
            n_bad++;
            $display("FAIL sync_n[%0d]: got %b need 0", k, vga_sync_n[k]);
          end

          if (pos[k] == 0) begin
            seen[k] = 1'b0;
          end else if (!seen[k] && prev_hs[k] == !c_hsp[k] && vga_hs[k] == c_hsp[k]) begin
            seen[k] = 1'b1;
            n_cmp++;
            if (pos[k] != c_ha[k] + c_hfp[k] + c_lat[k] + 1) begin
              n_bad++;
              $display("FAIL first_hs[%0d]: got edge at %0d need %0d",
                       k, pos[k], c_ha[k] + c_hfp[k] + c_lat[k] + 1);
            end
          end
          prev_hs[k] = vga_hs[k];
        end
      end
    end
  end

  initial begin : stimulus
    reset = 1'b1;
    repeat (3) @(posedge vga_clk);
    @(negedge vga_clk);
    reset = 1'b0;

    // Mid-line reset on the default raster: line 2, hcnt 300
    for (int i = 0; i < 3000 && pos[0] != 1900; i++) @(negedge vga_clk);
    if (pos[0] != 1900) to_err = 1'b1;
    reset = 1'b1;
    @(negedge vga_clk);
    reset = 1'b0;

    repeat (4000) @(negedge vga_clk);
    reset = 1'b1;
    repeat ($urandom_range(1, 3)) @(negedge vga_clk);
    reset = 1'b0;

    repeat (7000) @(negedge vga_clk);
    done = 1'b1;
  end

endmodule

`default_nettype wire

// File: doc/vga_timing_ctrl.md
Name: vga_timing_ctrl

Overview:
Sequencer for the VGA pixel path, clocked in the vga_clk domain produced by the PLL. It generates the horizontal and vertical raster counters and issues per-pixel requests (x, y) to the renderer LATENCY cycles ahead of display. It then drives the registered vga_hs/vs, blank_n and sync_n outputs, with the renderer's RGB gated to black outside the active area, all aligned to the requested pixel. Default timing is 640x480@60 at 25.175 MHz.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
HS_POL, 0, active level of vga_hs during sync
VS_POL, 0, active level of vga_vs during sync
LATENCY, 2, renderer latency in cycles from request to pixel data (range 1..8)
CW, 10, counter/coordinate width; must hold H_TOTAL-1 and V_TOTAL-1

Ports:
vga_clk  in  1  pixel clock
reset  in  1  synchronous, active-high reset
req_valid  out  1  request refers to an active pixel
req_x  out  CW  requested pixel column
req_y  out  CW  requested pixel row
frame_start  out  1  one-cycle pulse when the request counter is at (0,0)
line_start  out  1  one-cycle pulse when the request hcount is 0
pix_r  in  8  renderer red, valid LATENCY cycles after its request
pix_g  in  8  renderer green
pix_b  in  8  renderer blue
vga_hs  out  1  horizontal sync
vga_vs  out  1  vertical sync
vga_r  out  8  red to DAC
vga_g  out  8  green to DAC
vga_b  out  8  blue to DAC
vga_blank_n  out  1  low outside the active area
vga_sync_n  out  1  constant 0 (no sync-on-green)

Behaviour:
- Clock and reset: one clock (vga_clk). Reset is synchronous and active-high and named reset.
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800). V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
- Counters hcnt and vcnt are registers; reset sets both to 0.
- Counter sequencing:
  - hcnt increments every cycle and wraps H_TOTAL-1 -> 0.
  - vcnt increments only on the hcnt wrap cycle.
  - vcnt wraps V_TOTAL-1 -> 0 when hcnt also wraps.
- Request side is combinational from the counter registers:
  - req_x = hcnt, req_y = vcnt.
  - req_valid = (hcnt < H_ACTIVE) && (vcnt < V_ACTIVE).
  - line_start = (hcnt == 0); frame_start = (hcnt == 0 && vcnt == 0).
- Sync windows (request time):
  - hsync_raw = H_ACTIVE+H_FP <= hcnt < H_ACTIVE+H_FP+H_SYNC.
  - vsync_raw = V_ACTIVE+V_FP <= vcnt < V_ACTIVE+V_FP+V_SYNC (whole lines, changes on the hcnt wrap).
- Delay line: {req_valid, hsync_raw, vsync_raw} enter a shift register of depth LATENCY.
- Output register: on every cycle the output stage loads:
  - vga_hs = hsync_d ? HS_POL : ~HS_POL; vga_vs likewise with VS_POL.
  - vga_blank_n = valid_d.
  - vga_r/g/b = valid_d ? pix_r/g/b : 0.
- Latency: a request issued in cycle t appears on all vga_* outputs in cycle t+LATENCY+1. RGB input is sampled at t+LATENCY.
- Reset values:
  - Counters = 0; delay-line stages = {0,0,0}.
  - vga_hs = ~HS_POL, vga_vs = ~VS_POL.
  - vga_r/g/b = 0, vga_blank_n = 0, vga_sync_n = 0.
  - Request outputs reflect counters (0,0): req_valid = 1, frame_start = 1 during and after reset.
- Reset mid-frame: in the first cycle after reset is sampled high, every output shows its reset value. The raster restarts at (0,0) in the first cycle after reset deasserts. No partial line or stale delay-line contents reach the outputs.
- Any input value outside the active area is ignored; RGB is forced to 0 there.
- No back-pressure exists: the renderer must meet LATENCY exactly.

Decomposition:
- Shared package vga_pkg holds:
  - the default 640x480@60 timing constants and CW;
  - H_TOTAL/V_TOTAL derivation functions;
  - a typedef for the 3-bit control tuple {valid, hs, vs}.
- One sub-module, vga_delay_line (parameters DEPTH and WIDTH, synchronous clear on reset), implements the LATENCY shift register. Counters and the output stage stay in vga_timing_ctrl.

Test Plan:
- Release reset at cycle 0 with LATENCY=2:
  - frame_start=1 and req=(0,0) at cycle 0;
  - vga_hs first goes low at cycle 659 and returns high at cycle 755;
  - line period is 800 cycles.
- Run one full frame:
  - exactly 307200 cycles with vga_blank_n=1;
  - frame_start pulses every 420000 cycles;
  - vga_vs is low for exactly 1600 cycles starting at cycle 490*800+3.
- Wrap: at hcnt=799, vcnt=524, the next cycle has hcnt=0, vcnt=0, with frame_start=1 and line_start=1.
- Gating and alignment:
  - Drive pix_r/g/b = {hcnt[7:0], vcnt[7:0], 8'hFF} delayed by 2. vga_r must equal req_x of 3 cycles earlier in the active area.
  - Drive pix=FF/FF/FF during blanking: vga_r/g/b=0.
- Reset mid-frame at line 200, hcnt 300, held 1 cycle:
  - next cycle shows vga_hs=1, vga_vs=1, blank_n=0, rgb=0;
  - req=(0,0) after release; first vga_hs low exactly 659 cycles after release.
- Parameter sweep LATENCY=1 and LATENCY=8: hs and blank edges shift to t+2 and t+9; RGB alignment holds.
